led_chain_serializer: RTL

//  Parametrised WS2812-class LED-chain driver: latches a full set of N_LEDS pixel words and drives the

---
 rtl/led_chain_serializer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/led_chain_serializer.sv
// Single-wire LED chain driver: snapshots N_LEDS pixel words, then serialises them
// with on-chip high/low bit timing followed by a forced-low latch gap.
module led_chain_serializer #(
    parameter int N_LEDS       = 8,
    parameter int BITS_PER_LED = 24,
    parameter int MSB_FIRST    = 1,
    parameter int T0H          = 14,
    parameter int T1H          = 28,
    parameter int TBIT         = 50,
    parameter int TRESET       = 2000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [N_LEDS*BITS_PER_LED-1:0]   frames,
    output logic                             ready,
    output logic                             busy,
    output logic                             dout,
    output logic                             led_done,
    output logic                             new_frames_set_rqst,
    output logic [((N_LEDS > 1) ? $clog2(N_LEDS) : 1)-1:0]             led_idx_dbg,
    output logic [((BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1)-1:0] bit_idx_dbg
);
    localparam int LW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int BW = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
    localparam int CW = $clog2(TBIT + 1);
    localparam int GW = $clog2(TRESET + 1);
    localparam logic [BW-1:0] FIRST_BIT = (MSB_FIRST != 0) ? BW'(BITS_PER_LED - 1) : '0;
    localparam logic [BW-1:0] LAST_BIT  = (MSB_FIRST != 0) ? '0 : BW'(BITS_PER_LED - 1);

    if (N_LEDS < 1 || BITS_PER_LED < 1 || T0H < 1 || T1H <= T0H || TBIT <= T1H || TRESET < 1)
    begin : g_bad_params
        $error("led_chain_serializer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                            r_state;
    logic [N_LEDS*BITS_PER_LED-1:0]    r_shadow;
    logic [CW-1:0]                     r_cyc;
    logic [BW-1:0]                     r_bit;
    logic [LW-1:0]                     r_led;
    logic [GW-1:0]                     r_gap;
    logic                              r_dout;
    logic                              r_ready;
    logic                              r_busy;
    logic                              r_led_done;
    logic                              r_rqst;

    logic                              w_slot_end;
    logic                              w_word_end;
    logic                              w_set_end;
    logic [CW-1:0]                     w_nxt_cyc;
    logic [BW-1:0]                     w_nxt_bit;
    logic [LW-1:0]                     w_nxt_led;
    logic [N_LEDS*BITS_PER_LED-1:0]    w_shadow_shift;
    logic                              w_nxt_high;
    logic                              w_nxt_done;

    // Position of the cycle that follows the current one, so dout/led_done stay registered.
    always_comb begin
        w_slot_end = (r_cyc == CW'(TBIT - 1));
        w_word_end = w_slot_end && (r_bit == LAST_BIT);
        w_set_end  = w_word_end && (r_led == LW'(N_LEDS - 1));
        w_nxt_cyc  = w_slot_end ? '0 : r_cyc + 1'b1;
        w_nxt_bit  = r_bit;
        if (w_slot_end) begin
            if (w_word_end)
                w_nxt_bit = FIRST_BIT;
            else if (MSB_FIRST != 0)
                w_nxt_bit = r_bit - 1'b1;
            else
                w_nxt_bit = r_bit + 1'b1;
        end
        w_nxt_led = r_led;
        if (w_word_end && !w_set_end)
            w_nxt_led = r_led + 1'b1;
        w_shadow_shift = r_shadow >> (int'(w_nxt_led) * BITS_PER_LED + int'(w_nxt_bit));
        w_nxt_high = w_nxt_cyc < (w_shadow_shift[0] ? CW'(T1H) : CW'(T0H));
        w_nxt_done = (w_nxt_cyc == CW'(TBIT - 1)) && (w_nxt_bit == LAST_BIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shadow   <= '0;
            r_cyc      <= '0;
            r_bit      <= '0;
            r_led      <= '0;
            r_gap      <= '0;
            r_dout     <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_led_done <= 1'b0;
            r_rqst     <= 1'b0;
        end else begin
            r_led_done <= 1'b0;
            r_rqst     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_SEND;
                        r_shadow <= frames;
                        r_cyc    <= '0;
                        r_bit    <= FIRST_BIT;
                        r_led    <= '0;
                        // Slot cycle 0 is high for either bit value since T0H >= 1.
                        r_dout   <= 1'b1;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_set_end) begin
                        r_state <= ST_GAP;
                        r_cyc   <= '0;
                        r_bit   <= '0;
                        r_led   <= '0;
                        r_gap   <= '0;
                        r_dout  <= 1'b0;
                    end else begin
                        r_cyc      <= w_nxt_cyc;
                        r_bit      <= w_nxt_bit;
                        r_led      <= w_nxt_led;
                        r_dout     <= w_nxt_high;
                        r_led_done <= w_nxt_done;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GW'(TRESET - 1)) begin
                        r_state <= ST_IDLE;
                        r_gap   <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_rqst  <= 1'b1;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_dout  <= 1'b0;
                end
            endcase
        end
    end

    assign ready               = r_ready;
    assign busy                = r_busy;
    assign dout                = r_dout;
    assign led_done            = r_led_done;
    assign new_frames_set_rqst = r_rqst;
    assign led_idx_dbg         = r_led;
    assign bit_idx_dbg         = r_bit;
endmodule
